// File: rtl/led_sequencer.sv
// LED pattern sequencer: OFF / BLINK / CHASE / BREATHE patterns advanced every STEP_TICKS tick strobes.
// All outputs registered; breathe output is a PWM compare of a free-running counter against a triangle duty.
module led_sequencer #(
  parameter int STEP_TICKS = 4,
  parameter int PWM_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic       mode_load,
  output logic [4:0] led,
  output logic       step_out
);

  localparam logic [7:0]          LAST_TICK = 8'(STEP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_BLINK   = 2'd1,
    M_CHASE   = 2'd2,
    M_BREATHE = 2'd3
  } mode_t;

  mode_t               cur_mode;
  logic [7:0]          tick_cnt;
  logic [3:0]          pos;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                dir;
  logic                step;
  logic [3:0]          pos_nxt;

  assign step = tick && (tick_cnt == LAST_TICK) && !mode_load;

  // Chase LEDs are driven from the post-rotation position so led[3:0] always equals pos.
  always_comb begin
    pos_nxt = pos;
    if (step) pos_nxt = {pos[2:0], pos[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= M_OFF;
      tick_cnt <= '0;
      pos      <= 4'b0001;
      duty     <= '0;
      dir      <= 1'b0;
      pwm_cnt  <= '0;
      led      <= '0;
      step_out <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_out <= step;
      if (mode_load) begin
        cur_mode <= mode_t'(mode);
        tick_cnt <= '0;
        pos      <= 4'b0001;
        duty     <= '0;
        dir      <= 1'b0;
        led      <= '0;
      end else begin
        if (tick) tick_cnt <= (tick_cnt == LAST_TICK) ? 8'd0 : tick_cnt + 8'd1;
        case (cur_mode)
          M_OFF:   led <= '0;
          M_BLINK: if (step) led <= ~led;
          M_CHASE: begin
            pos <= pos_nxt;
            led <= {1'b1, pos_nxt};
          end
          M_BREATHE: begin
            led <= {pwm_cnt < duty, 4'b0000};
            // Triangle ramp: turn around at the ends instead of wrapping.
            if (step) begin
              if (!dir) begin
                if (duty == DUTY_MAX) begin
                  duty <= DUTY_MAX - 1'b1;
                  dir  <= 1'b1;
                end else begin
                  duty <= duty + 1'b1;
                end
              end else begin
                if (duty == '0) begin
                  duty <= 1;
                  dir  <= 1'b0;
                end else begin
                  duty <= duty - 1'b1;
                end
              end
            end
          end
          default: led <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboarded bench for led_sequencer with STEP_TICKS=4, PWM_BITS=4.
module tb_led_sequencer;

  localparam int STEP = 4;
  localparam int PWMB = 4;
  localparam int DMAX = (1 << PWMB) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       mode_load = 1'b0;
  logic [4:0] led;
  logic       step_out;

  led_sequencer #(.STEP_TICKS(STEP), .PWM_BITS(PWMB)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .mode_load(mode_load),
    .led(led), .step_out(step_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int steps_seen = 0;
  int hi_cnt = 0;

  logic [5:0] exp_q[$];

  // reference model state
  int         m_mode, m_tcnt, m_k, m_pwm;
  logic [4:0] e_led;
  logic       e_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Triangle duty after k breathe steps: 0,1..MAX,MAX-1..0,1..
  function automatic int duty_of(input int k);
    int p;
    p = k % (2 * DMAX);
    return (p <= DMAX) ? p : (2 * DMAX - p);
  endfunction

  task automatic model_edge(input logic r, input logic t, input logic ml, input logic [1:0] m);
    int pwm_old, k_old;
    if (r) begin
      m_mode = 0; m_tcnt = 0; m_k = 0; m_pwm = 0;
      e_led = '0; e_step = 1'b0;
    end else begin
      pwm_old = m_pwm;
      m_pwm = (m_pwm + 1) % (1 << PWMB);
      k_old = m_k;
      if (ml) begin
        m_mode = int'(m); m_tcnt = 0; m_k = 0;
        e_led = '0; e_step = 1'b0;
      end else begin
        e_step = t && (m_tcnt == STEP - 1);
        if (t) m_tcnt = e_step ? 0 : m_tcnt + 1;
        if (e_step) m_k++;
        case (m_mode)
          1: e_led = m_k[0] ? 5'h1f : 5'h00;
          2: e_led = {1'b1, 4'(1 << (m_k % 4))};
          3: e_led = {(pwm_old < duty_of(k_old)), 4'b0000};
          default: e_led = '0;
        endcase
      end
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic ml, input logic [1:0] m);
    logic [5:0] e;
    @(negedge clk);
    rst = r; tick = t; mode_load = ml; mode = m;
    model_edge(r, t, ml, m);
    exp_q.push_back({e_step, e_led});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("led", 32'(led), 32'(e[4:0]));
    check("step_out", 32'(step_out), 32'(e[5]));
    if (step_out === 1'b1) steps_seen++;
    if (led[4] === 1'b1) hi_cnt++;
  endtask

  task automatic ticks(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 2'd0);
      if (gap) cyc(1'b0, 1'b0, 1'b0, 2'd0);
    end
  endtask

  task automatic load(input logic [1:0] m);
    cyc(1'b0, 1'b0, 1'b1, m);
  endtask

  task automatic pwm_window;
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    hi_cnt = 0;
    for (int i = 0; i < (1 << PWMB); i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
    check("pwm_window", 32'(hi_cnt), 32'(duty_of(m_k)));
  endtask

  initial begin
    // reset
    cyc(1'b1, 1'b1, 1'b1, 2'd2);
    cyc(1'b1, 1'b0, 1'b0, 2'd0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_step", 32'(step_out), 32'h0);

    // mode 0: led stays dark, 3 steps from 12 ticks
    steps_seen = 0;
    ticks(12, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    check("off_steps", 32'(steps_seen), 32'd3);

    // chase: 8 ticks -> two steps, pos 0100
    load(2'd2);
    steps_seen = 0;
    ticks(8, 1'b1);
    check("chase_steps", 32'(steps_seen), 32'd2);
    check("chase_led", 32'(led), 32'h14);

    // blink with back-to-back ticks
    load(2'd1);
    steps_seen = 0;
    ticks(12, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    check("blink_steps", 32'(steps_seen), 32'd3);
    check("blink_led", 32'(led), 32'h1f);

    // mode_load coincident with the completing tick suppresses the step
    load(2'd1);
    ticks(3, 1'b0);
    steps_seen = 0;
    cyc(1'b0, 1'b1, 1'b1, 2'd1);
    ticks(3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    check("coincide_nostep", 32'(steps_seen), 32'd0);
    check("coincide_led", 32'(led), 32'h0);
    ticks(1, 1'b1);
    check("coincide_step4", 32'(steps_seen), 32'd1);

    // reset mid-chase abandons the pattern
    load(2'd2);
    ticks(10, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_step", 32'(step_out), 32'h0);
    ticks(8, 1'b0);
    check("midrst_after", 32'(led), 32'h0);

    // breathe: 40 steps with PWM windows at a few duty points
    load(2'd3);
    pwm_window();
    for (int s = 1; s <= 40; s++) begin
      ticks(STEP, 1'b0);
      if (s == 7 || s == 15 || s == 16 || s == 20 || s == 30 || s == 33 || s == 40)
        pwm_window();
    end

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
